pcm_tdm_tx: RTL and testbench
=============================

PCM_TDM_TX -- requirements
Module: pcm_tdm_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- CHANNELS, 4, channels per frame (1..32).
- SYNC_WORD, 8'h9B, frame alignment byte.
- INVERT_EVEN, 1, XOR each code byte with 8'h55 when 1.
REQ-002 Ports, one per line: name direction width meaning:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- bit_en  input  1  serial bit-rate tick; advances output one bit.
- in_data  input  13*CHANNELS  two's-complement samples; ch0 in [12:0], chN in [13N+12:13N].
- in_valid  input  1  sample set offered.
- in_ready  output  1  holding buffer empty.
- ser_out  output  1  serial TDM stream, MSB first.
- frame_start  output  1  one-cycle pulse, first sync bit presented.
- ch_idx  output  5  channel of the byte now on ser_out; 0 during sync/idle.
- busy  output  1  frame in progress.

Function
REQ-003 Accept rule: transfer on a cycle with in_valid && in_ready; all CHANNELS samples captured together.
REQ-004 in_ready = !hold_full && !rst; no combinational path from in_valid.
REQ-005 Compression at capture, per channel; an 8-bit code is stored, not the 13-bit sample.
REQ-006 Sign: s=1 for sample >= 0, else 0.
REQ-007 Magnitude: m = |sample| (12 bits); -4096 clamps to 4095.
REQ-008 Segment/mantissa: m<32 -> seg=0, q=m[4:1]; otherwise k = MSB index of m (5..11), seg=k-4, q=m[k-1:k-4].
REQ-009 Code = {s, seg[2:0], q[3:0]}, XORed with 8'h55 when INVERT_EVEN=1.
REQ-010 Engine FSM states: IDLE, SYNC, DATA.
REQ-011 IDLE with hold_full: next edge moves holding -> shift buffer, clears hold_full, enters SYNC; bit_en not required.
REQ-012 In SYNC, SYNC_WORD bit7 is on ser_out from the first SYNC cycle; frame_start=1 for that cycle only.
REQ-013 Each bit stays on ser_out until a cycle with bit_en=1; the next edge advances one bit.
REQ-014 After SYNC bit0 with bit_en, enter DATA at ch0 bit7; channels are sent 0..CHANNELS-1, each MSB first.
REQ-015 Frame length is exactly 8*(CHANNELS+1) bit_en ticks.
REQ-016 End of frame (last data bit with bit_en), hold_full=1: reload, go to SYNC with no gap bit.
REQ-017 End of frame, hold_full=0: go to IDLE.
REQ-018 IDLE: ser_out=1, ch_idx=0, busy=0; busy=1 in SYNC and DATA.
REQ-019 Capture into holding is allowed at any point in a frame; the shift buffer is unaffected until reload.
REQ-020 On the reload cycle in_ready is still 0; it is 1 on the following cycle.
REQ-021 bit_en is ignored in IDLE.
REQ-022 A bit_en held high advances one bit per clock.

Reset
REQ-023 With rst=1 at an edge, the next cycle shows: FSM=IDLE, hold_full=0, shift and holding buffers cleared, ser_out=1, frame_start=0, ch_idx=0, busy=0, in_ready=0 while rst is high.
REQ-024 Reset mid-frame abandons the frame with no trailing bits.
REQ-025 in_ready=1 on the first cycle after rst falls.

Verification
REQ-026 INVERT_EVEN=0, CHANNELS=1, bit_en=1, sample 0: stream 10011011 then 10000000, then ser_out=1 idle; frame_start pulses once.
REQ-027 INVERT_EVEN=0 code checks:
- 4095 -> 8'hFF.
- -4096 -> 8'h7F.
- 33 -> 8'h90.
- 31 -> 8'h8F.
- -1 -> 8'h00.
REQ-028 INVERT_EVEN=1, sample 0 -> 8'hD5; 4095 -> 8'hAA.
REQ-029 CHANNELS=4, bit_en every 3rd cycle, second set offered mid-frame: exactly 40 ticks per frame, and the second frame's sync follows the first frame's last bit with no idle bit.
REQ-030 Reset asserted during ch2 bit4: ser_out=1 and busy=0 on the next cycle; a new sample set afterwards produces a clean full frame.
REQ-031 in_valid held high continuously: in_ready low while holding is full, and no sample set is lost or duplicated (scoreboard against a reference compressor).

Source files
------------

// File: rtl/pcm_tdm_tx.sv
// pcm_tdm_tx: compresses a set of 13-bit PCM samples to 8-bit codes and
// serialises them as a TDM frame (sync byte, then channels 0..N-1, MSB first).
module pcm_tdm_tx #(
    parameter int CHANNELS = 4,
    parameter logic [7:0] SYNC_WORD = 8'h9B,
    parameter int INVERT_EVEN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_en,
    input  logic [13*CHANNELS-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    ser_out,
    output logic                    frame_start,
    output logic [4:0]              ch_idx,
    output logic                    busy
);
    localparam int W = 8 * CHANNELS;

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t       state, state_n;
    logic         hold_full, first, reload, last;
    logic [W-1:0] hold_buf, shift_buf, codes;
    logic [2:0]   bit_cnt;
    logic [4:0]   ch;

    function automatic logic [7:0] compress(input logic [12:0] x);
        logic [12:0] a;
        logic [11:0] m;
        logic [2:0]  seg;
        logic [3:0]  q;
        a = x[12] ? 13'(-x) : x;
        m = a[12] ? 12'hFFF : a[11:0];
        seg = 3'd0;
        q = m[4:1];
        for (int k = 5; k < 12; k++)
            if (m[k]) begin
                seg = 3'(k - 4);
                q = 4'(m >> (k - 4));
            end
        return {~x[12], seg, q} ^ (INVERT_EVEN != 0 ? 8'h55 : 8'h00);
    endfunction

    // ch0 lands in the top byte so the frame shifts out of the MSB
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
        assign codes[W-8-8*c +: 8] = compress(in_data[13*c +: 13]);
    end

    always_comb begin
        state_n = state;
        reload = 1'b0;
        last = bit_en && bit_cnt == 3'd0;
        case (state)
            IDLE: begin
                state_n = hold_full ? SYNC : IDLE;
                reload = hold_full;
            end
            SYNC: state_n = last ? DATA : SYNC;
            DATA: if (last && ch == 5'(CHANNELS - 1)) begin
                reload = hold_full;
                state_n = hold_full ? SYNC : IDLE;
            end
            default: state_n = IDLE;
        endcase
        in_ready = !hold_full && !rst;
        busy = state != IDLE;
        frame_start = first;
        ch_idx = state == DATA ? ch : 5'd0;
        ser_out = state == SYNC ? SYNC_WORD[bit_cnt] : state == DATA ? shift_buf[W-1] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hold_full <= 1'b0;
            hold_buf <= '0;
            shift_buf <= '0;
            bit_cnt <= 3'd7;
            ch <= 5'd0;
            first <= 1'b0;
        end else begin
            state <= state_n;
            first <= reload;
            if (reload) begin
                shift_buf <= hold_buf;
                hold_full <= 1'b0;
                bit_cnt <= 3'd7;
                ch <= 5'd0;
            end else if (busy && bit_en) begin
                bit_cnt <= bit_cnt - 3'd1;
                if (state == DATA) begin
                    shift_buf <= shift_buf << 1;
                    if (bit_cnt == 3'd0) ch <= ch + 5'd1;
                end
            end
            if (in_valid && in_ready) begin
                hold_buf <= codes;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcm_tdm_tx.sv
// tb_pcm_tdm_tx: frame-level model of the TDM transmitter checked every cycle,
// plus directed frames with hand-computed code bytes.
module tb_pcm_tdm_tx;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1, bit_en = 1'b0, in_valid = 1'b0;
    logic [13*C-1:0]  in_data = '0;
    logic             in_ready, ser_out, frame_start, busy;
    logic [4:0]       ch_idx;

    logic             rst1 = 1'b1, bit_en1 = 1'b0, in_valid1 = 1'b0;
    logic [12:0]      in_data1 = '0;
    logic             in_ready1, ser_out1, frame_start1, busy1;
    logic [4:0]       ch_idx1;

    pcm_tdm_tx #(.CHANNELS(C), .SYNC_WORD(8'h9B), .INVERT_EVEN(0)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .frame_start(frame_start),
        .ch_idx(ch_idx), .busy(busy)
    );

    pcm_tdm_tx #(.CHANNELS(1), .SYNC_WORD(8'h9B), .INVERT_EVEN(1)) dut1 (
        .clk(clk), .rst(rst1), .bit_en(bit_en1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_out(ser_out1), .frame_start(frame_start1),
        .ch_idx(ch_idx1), .busy(busy1)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Reference compressor written straight from the A-law-like rules
    function automatic logic [7:0] ref_code(input int v, input bit inv);
        int m, k, seg, q;
        m = v < 0 ? -v : v;
        if (m > 4095) m = 4095;
        if (m < 32) begin
            seg = 0;
            q = m / 2;
        end else begin
            k = 5;
            while ((m >> (k + 1)) != 0) k++;
            seg = k - 4;
            q = (m >> (k - 4)) & 15;
        end
        return 8'((v >= 0 ? 128 : 0) + seg * 16 + q) ^ (inv ? 8'h55 : 8'h00);
    endfunction

    typedef struct {
        bit       b;
        bit [4:0] ch;
        bit       first;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  pend_codes[C];
    logic [7:0]  rx[$];
    logic [7:0]  sw = 8'h9B, acc8 = '0;
    logic signed [12:0] smp;
    bit          pend = 0, shown = 0, started = 0, prev_busy = 0;
    bit          e_busy, e_ser, e_fs, e_rdy;
    bit [4:0]    e_ch;
    int          n8 = 0, fs_cnt = 0, tick_cnt = 0, fall_cnt = 0, acc_cnt = 0;
    int          mode = 0, ph = 0;

    // Model: the bit stream of the frame in flight; the next accepted set
    // starts the moment the current stream runs dry.
    always @(negedge clk) begin
        if (started) begin
            e_busy = q.size() != 0;
            e_ser = e_busy ? q[0].b : 1'b1;
            e_ch = e_busy ? q[0].ch : 5'd0;
            e_fs = e_busy && q[0].first && !shown;
            e_rdy = !pend && !rst;
            chk("outputs{busy,ser,fs,ch,rdy}", {busy, ser_out, frame_start, ch_idx, in_ready},
                {e_busy, e_ser, e_fs, e_ch, e_rdy});
            if (frame_start) fs_cnt++;
            if (prev_busy && !busy) fall_cnt++;
            prev_busy = busy;
            if (busy && bit_en) begin
                tick_cnt++;
                acc8 = {acc8[6:0], ser_out};
                n8++;
                if (n8 == 8) begin
                    rx.push_back(acc8);
                    n8 = 0;
                end
            end
            if (rst) begin
                q.delete();
                pend = 0;
                shown = 0;
                n8 = 0;
            end else begin
                if (q.size() != 0) begin
                    if (bit_en) begin
                        void'(q.pop_front());
                        shown = 0;
                    end else shown = 1;
                end
                if (q.size() == 0 && pend) begin
                    for (int i = 7; i >= 0; i--) q.push_back('{sw[i], 5'd0, i == 7});
                    for (int c = 0; c < C; c++)
                        for (int i = 7; i >= 0; i--) q.push_back('{pend_codes[c][i], 5'(c), 1'b0});
                    pend = 0;
                end
                if (in_valid && e_rdy) begin
                    for (int c = 0; c < C; c++) begin
                        smp = in_data[13*c +: 13];
                        pend_codes[c] = ref_code(int'(smp), 1'b0);
                    end
                    pend = 1;
                    acc_cnt++;
                end
            end
        end
        if (rst) started = 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            bit_en = mode == 0 ? 1'b1 : mode == 1 ? (ph % 3 == 0) : ($urandom_range(0, 1) == 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [13*C-1:0] d);
        int k;
        in_data = d;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 400) begin
            step();
            k++;
        end
        chk("offer_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !in_ready) && k < 2000) begin
            step();
            k++;
        end
        chk("idle_timeout", k < 2000, 1);
        step();
    endtask

    task automatic check_bytes(input string nm, input int base, input logic [39:0] e);
        chk({nm, "_count"}, rx.size() >= base + 5, 1);
        if (rx.size() >= base + 5)
            for (int i = 0; i < 5; i++) chk($sformatf("%s_byte%0d", nm, i), rx[base+i], e[39-8*i -: 8]);
    endtask

    task automatic d1_frame(input logic [12:0] s, input logic [15:0] e);
        int k, fs1;
        in_data1 = s;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        k = 0;
        while (!busy1 && k < 5) begin
            step();
            k++;
        end
        chk("d1_start", busy1, 1);
        fs1 = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("d1_bit%0d", i), ser_out1, e[15-i]);
            fs1 += int'(frame_start1);
            step();
        end
        chk("d1_idle{busy,ser}", {busy1, ser_out1}, 2'b01);
        chk("d1_fs_pulses", fs1, 1);
    endtask

    localparam logic [13*C-1:0] DA = {13'd31, 13'd33, 13'h1000, 13'd4095};
    localparam logic [13*C-1:0] DB = {13'h1FDF, 13'd1, 13'd0, 13'h1FFF};
    localparam logic [39:0] BA = 40'h9B_FF_7F_90_8F;
    localparam logic [39:0] BB = 40'h9B_00_80_80_10;

    initial begin
        int base, t0, f0, fl0, a0, lowcnt, k;
        mode = 0;
        repeat (2) step();
        chk("rst_ready", in_ready, 0);
        chk("rst_idle{busy,ser,fs,ch}", {busy, ser_out, frame_start, ch_idx}, {1'b0, 1'b1, 1'b0, 5'd0});
        rst = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        step();

        bit_en1 = 1'b1;
        d1_frame(13'd0, 16'h9BD5);
        d1_frame(13'd4095, 16'h9BAA);

        base = rx.size();
        offer(DA);
        wait_idle();
        check_bytes("codesA", base, BA);
        base = rx.size();
        offer(DB);
        wait_idle();
        check_bytes("codesB", base, BB);

        mode = 1;
        t0 = tick_cnt;
        f0 = fs_cnt;
        fl0 = fall_cnt;
        base = rx.size();
        offer(DA);
        k = 0;
        while (!busy && k < 10) begin
            step();
            k++;
        end
        repeat (60) step();
        offer(DB);
        wait_idle();
        chk("b2b_ticks", tick_cnt - t0, 80);
        chk("b2b_frames", fs_cnt - f0, 2);
        chk("b2b_busy_falls", fall_cnt - fl0, 1);
        check_bytes("b2b_first", base, BA);
        check_bytes("b2b_second", base + 5, BB);

        mode = 0;
        step();
        offer(DA);
        k = 0;
        while (ch_idx != 5'd2 && k < 100) begin
            step();
            k++;
        end
        chk("reach_ch2", ch_idx, 2);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("abort{ser,busy}", {ser_out, busy}, 2'b10);
        rst = 1'b0;
        step();
        base = rx.size();
        offer(DB);
        wait_idle();
        check_bytes("after_abort", base, BB);

        mode = 2;
        a0 = acc_cnt;
        f0 = fs_cnt;
        lowcnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_data = (i % 7 == 0) ? DA : (i % 11 == 0) ? DB : 52'({$urandom(), $urandom()});
            if (!in_ready) lowcnt++;
            step();
        end
        in_valid = 1'b0;
        wait_idle();
        chk("stream_frames_vs_accepts", fs_cnt - f0, acc_cnt - a0);
        chk("stream_backpressure_seen", lowcnt > 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
